// File: rtl/sdr_port_arbiter.sv
// Shares one SDRAM controller port between the CPU, background tile fetch and sprite fetch.
// One transaction outstanding; CPU priority with a starvation cap, bg/spr round-robin.
module sdr_port_arbiter #(
    parameter int ADDR_W         = 25,
    parameter int CPU_MAX_CONSEC = 4
) (
    input  logic              CLK_96M,
    input  logic              reset_n,

    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [1:0]        cpu_wr_sel,
    input  logic [15:0]       cpu_din,
    output logic              cpu_rdy,
    output logic [15:0]       cpu_dout,

    input  logic              bg_req,
    input  logic [ADDR_W-1:0] bg_addr,
    output logic              bg_rdy,
    output logic [31:0]       bg_dout,

    input  logic              spr_req,
    input  logic [ADDR_W-1:0] spr_addr,
    output logic              spr_rdy,
    output logic [63:0]       spr_dout,

    output logic              sdr_req,
    output logic [ADDR_W-1:0] sdr_addr,
    output logic [1:0]        sdr_wr_sel,
    output logic [15:0]       sdr_din,
    input  logic              sdr_rdy,
    input  logic [63:0]       sdr_dout,

    output logic              busy
);

    // state | meaning
    // IDLE  | no transaction; arbitrate among pending requesters
    // WAIT  | sdr_req issued, waiting for sdr_rdy; downstream fields held
    // DONE  | winner's rdy is high; its pend clears; may grant the next winner directly
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    typedef enum logic [1:0] {SRC_CPU, SRC_BG, SRC_SPR} src_t;

    localparam logic [3:0] MAX_CONSEC = 4'(CPU_MAX_CONSEC);

    state_t            state;
    src_t              owner;
    logic              rr_spr;
    logic [3:0]        cpu_streak;

    logic              pend_cpu, pend_bg, pend_spr;
    logic [ADDR_W-1:0] cpu_addr_q, bg_addr_q, spr_addr_q;
    logic [1:0]        cpu_wr_sel_q;
    logic [15:0]       cpu_din_q;

    logic              clr_cpu, clr_bg, clr_spr;
    logic              acc_cpu, acc_bg, acc_spr;
    logic              pend_cpu_d, pend_bg_d, pend_spr_d;
    logic [ADDR_W-1:0] cpu_addr_d, bg_addr_d, spr_addr_d;
    logic [1:0]        cpu_wr_sel_d;
    logic [15:0]       cpu_din_d;
    logic              arb_cpu, arb_bg, arb_spr, arb_video;
    logic              grant;
    src_t              pick;

    always_comb begin
        clr_cpu = (state == DONE) && (owner == SRC_CPU);
        clr_bg  = (state == DONE) && (owner == SRC_BG);
        clr_spr = (state == DONE) && (owner == SRC_SPR);

        // A request is taken when not pending, or when it re-arms a completing slot.
        acc_cpu = cpu_req && (!pend_cpu || clr_cpu);
        acc_bg  = bg_req  && (!pend_bg  || clr_bg);
        acc_spr = spr_req && (!pend_spr || clr_spr);

        pend_cpu_d = acc_cpu || (pend_cpu && !clr_cpu);
        pend_bg_d  = acc_bg  || (pend_bg  && !clr_bg);
        pend_spr_d = acc_spr || (pend_spr && !clr_spr);

        cpu_addr_d   = acc_cpu ? cpu_addr   : cpu_addr_q;
        cpu_wr_sel_d = acc_cpu ? cpu_wr_sel : cpu_wr_sel_q;
        cpu_din_d    = acc_cpu ? cpu_din    : cpu_din_q;
        bg_addr_d    = acc_bg  ? bg_addr    : bg_addr_q;
        spr_addr_d   = acc_spr ? spr_addr   : spr_addr_q;

        // DONE arbitrates on next-cycle pend so a re-request during rdy is seen immediately.
        arb_cpu   = (state == DONE) ? pend_cpu_d : pend_cpu;
        arb_bg    = (state == DONE) ? pend_bg_d  : pend_bg;
        arb_spr   = (state == DONE) ? pend_spr_d : pend_spr;
        arb_video = arb_bg || arb_spr;

        grant = 1'b0;
        pick  = SRC_CPU;
        if (state == IDLE || state == DONE) begin
            if (arb_cpu && ((cpu_streak < MAX_CONSEC) || !arb_video)) begin
                grant = 1'b1;
                pick  = SRC_CPU;
            end else if (arb_video) begin
                grant = 1'b1;
                if (rr_spr)
                    pick = arb_spr ? SRC_SPR : SRC_BG;
                else
                    pick = arb_bg ? SRC_BG : SRC_SPR;
            end
        end
    end

    always_ff @(posedge CLK_96M or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            owner        <= SRC_CPU;
            rr_spr       <= 1'b0;
            cpu_streak   <= 4'd0;
            pend_cpu     <= 1'b0;
            pend_bg      <= 1'b0;
            pend_spr     <= 1'b0;
            cpu_addr_q   <= '0;
            cpu_wr_sel_q <= 2'b00;
            cpu_din_q    <= 16'h0;
            bg_addr_q    <= '0;
            spr_addr_q   <= '0;
            cpu_rdy      <= 1'b0;
            cpu_dout     <= 16'h0;
            bg_rdy       <= 1'b0;
            bg_dout      <= 32'h0;
            spr_rdy      <= 1'b0;
            spr_dout     <= 64'h0;
            sdr_req      <= 1'b0;
            sdr_addr     <= '0;
            sdr_wr_sel   <= 2'b00;
            sdr_din      <= 16'h0;
        end else begin
            pend_cpu     <= pend_cpu_d;
            pend_bg      <= pend_bg_d;
            pend_spr     <= pend_spr_d;
            cpu_addr_q   <= cpu_addr_d;
            cpu_wr_sel_q <= cpu_wr_sel_d;
            cpu_din_q    <= cpu_din_d;
            bg_addr_q    <= bg_addr_d;
            spr_addr_q   <= spr_addr_d;

            sdr_req <= 1'b0;
            cpu_rdy <= 1'b0;
            bg_rdy  <= 1'b0;
            spr_rdy <= 1'b0;

            unique case (state)
                IDLE, DONE: begin
                    if (grant) begin
                        state   <= WAIT;
                        owner   <= pick;
                        sdr_req <= 1'b1;
                        unique case (pick)
                            SRC_CPU: begin
                                sdr_addr   <= cpu_addr_d;
                                sdr_wr_sel <= cpu_wr_sel_d;
                                sdr_din    <= cpu_din_d;
                                if (arb_video)
                                    cpu_streak <= (cpu_streak == 4'hF) ? 4'hF : cpu_streak + 4'd1;
                                else
                                    cpu_streak <= 4'd0;
                            end
                            SRC_BG: begin
                                sdr_addr   <= bg_addr_d;
                                sdr_wr_sel <= 2'b00;
                                sdr_din    <= 16'h0;
                                cpu_streak <= 4'd0;
                                rr_spr     <= 1'b1;
                            end
                            default: begin
                                sdr_addr   <= spr_addr_d;
                                sdr_wr_sel <= 2'b00;
                                sdr_din    <= 16'h0;
                                cpu_streak <= 4'd0;
                                rr_spr     <= 1'b0;
                            end
                        endcase
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (sdr_rdy) begin
                        state <= DONE;
                        unique case (owner)
                            SRC_CPU: begin
                                cpu_dout <= sdr_dout[15:0];
                                cpu_rdy  <= 1'b1;
                            end
                            SRC_BG: begin
                                bg_dout <= sdr_dout[31:0];
                                bg_rdy  <= 1'b1;
                            end
                            default: begin
                                spr_dout <= sdr_dout;
                                spr_rdy  <= 1'b1;
                            end
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_sdr_port_arbiter.sv
// Scoreboard bench for sdr_port_arbiter: expected grants and completions are queued by the
// stimulus and consumed by a responder/monitor pair watching the DUT.
module tb_sdr_port_arbiter;

    localparam int LAT = 5;

    logic        CLK_96M = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic [24:0] cpu_addr = '0;
    logic [1:0]  cpu_wr_sel = 2'b00;
    logic [15:0] cpu_din = 16'h0;
    logic        cpu_rdy;
    logic [15:0] cpu_dout;
    logic        bg_req = 1'b0;
    logic [24:0] bg_addr = '0;
    logic        bg_rdy;
    logic [31:0] bg_dout;
    logic        spr_req = 1'b0;
    logic [24:0] spr_addr = '0;
    logic        spr_rdy;
    logic [63:0] spr_dout;
    logic        sdr_req;
    logic [24:0] sdr_addr;
    logic [1:0]  sdr_wr_sel;
    logic [15:0] sdr_din;
    logic        sdr_rdy = 1'b0;
    logic [63:0] sdr_dout = 64'h0;
    logic        busy;

    sdr_port_arbiter #(.ADDR_W(25), .CPU_MAX_CONSEC(4)) dut (
        .CLK_96M(CLK_96M), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wr_sel(cpu_wr_sel), .cpu_din(cpu_din),
        .cpu_rdy(cpu_rdy), .cpu_dout(cpu_dout),
        .bg_req(bg_req), .bg_addr(bg_addr), .bg_rdy(bg_rdy), .bg_dout(bg_dout),
        .spr_req(spr_req), .spr_addr(spr_addr), .spr_rdy(spr_rdy), .spr_dout(spr_dout),
        .sdr_req(sdr_req), .sdr_addr(sdr_addr), .sdr_wr_sel(sdr_wr_sel), .sdr_din(sdr_din),
        .sdr_rdy(sdr_rdy), .sdr_dout(sdr_dout), .busy(busy)
    );

    always #5 CLK_96M = ~CLK_96M;

    typedef struct {
        int          src;
        logic [24:0] addr;
        logic [1:0]  wr;
        logic [15:0] din;
        logic [63:0] data;
        bit          no_resp;
    } exp_t;

    exp_t        gq[$];
    exp_t        cq[$];
    logic [24:0] cpu_next[$];
    logic [24:0] bg_next[$];
    logic [24:0] spr_next[$];

    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    int  req_cyc = 0;
    int  rdy_cyc = 0;
    bit  check_lat = 0;
    bit  active = 0;
    bit  stray = 0;
    exp_t cur;
    logic [15:0] sh_cpu = 16'h0;
    logic [31:0] sh_bg = 32'h0;
    logic [63:0] sh_spr = 64'h0;

    always @(posedge CLK_96M) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input int src, input logic [24:0] addr, input logic [1:0] wr,
                        input logic [15:0] din, input logic [63:0] data, input bit no_resp);
        exp_t e;
        e.src = src; e.addr = addr; e.wr = wr; e.din = din; e.data = data; e.no_resp = no_resp;
        gq.push_back(e);
    endtask

    task automatic pulse(input bit c, input bit b, input bit s);
        @(negedge CLK_96M);
        cpu_req = c; bg_req = b; spr_req = s;
        req_cyc = cyc;
        @(negedge CLK_96M);
        cpu_req = 0; bg_req = 0; spr_req = 0;
    endtask

    // Runs until every queued expectation is consumed, re-requesting on rdy as scripted.
    task automatic run(input int budget, input string name);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK_96M);
            cpu_req = 0; bg_req = 0; spr_req = 0;
            if (cpu_rdy && cpu_next.size() > 0) begin
                cpu_req = 1; cpu_addr = cpu_next.pop_front(); cpu_wr_sel = 2'b00;
            end
            if (bg_rdy && bg_next.size() > 0) begin
                bg_req = 1; bg_addr = bg_next.pop_front();
            end
            if (spr_rdy && spr_next.size() > 0) begin
                spr_req = 1; spr_addr = spr_next.pop_front();
            end
            if (gq.size() == 0 && cq.size() == 0 && !active && !busy && !cpu_req && !bg_req &&
                !spr_req && cpu_next.size() == 0 && bg_next.size() == 0 && spr_next.size() == 0) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout: got pending=%0d expected 0", name, gq.size() + cq.size());
        end
    endtask

    // SDRAM responder and grant checker.
    initial begin
        forever begin
            @(negedge CLK_96M);
            sdr_rdy = 0;
            if (sdr_req === 1'b1) begin
                chk("grant_expected", 64'(gq.size() > 0), 64'd1);
                if (gq.size() > 0) begin
                    cur = gq.pop_front();
                    chk("grant_addr", 64'(sdr_addr), 64'(cur.addr));
                    chk("grant_wr_sel", 64'(sdr_wr_sel), 64'(cur.wr));
                    chk("grant_din", 64'(sdr_din), 64'(cur.din));
                    if (check_lat) begin
                        chk("req_latency", 64'(cyc - req_cyc), 64'd2);
                        check_lat = 0;
                    end
                    if (!cur.no_resp) begin
                        active = 1;
                        cq.push_back(cur);
                    end
                end
            end else if (active) begin
                if (cyc - req_cyc >= 0 && $urandom_range(0, 0) == 0) begin
                    chk("hold_addr", 64'(sdr_addr), 64'(cur.addr));
                    chk("hold_wr_sel", 64'(sdr_wr_sel), 64'(cur.wr));
                    chk("hold_din", 64'(sdr_din), 64'(cur.din));
                end
                repeat (LAT - 2) @(negedge CLK_96M);
                sdr_rdy = 1;
                sdr_dout = cur.data;
                rdy_cyc = cyc;
                active = 0;
            end else if (stray) begin
                sdr_rdy = 1;
                sdr_dout = 64'hFFFF_FFFF_FFFF_FFFF;
                stray = 0;
            end
        end
    end

    // Completion monitor.
    initial begin
        exp_t c;
        int   n;
        int   got;
        forever begin
            @(negedge CLK_96M);
            if (cpu_rdy || bg_rdy || spr_rdy) begin
                n = int'(cpu_rdy) + int'(bg_rdy) + int'(spr_rdy);
                chk("rdy_onehot", 64'(n), 64'd1);
                chk("rdy_expected", 64'(cq.size() > 0), 64'd1);
                if (cq.size() > 0) begin
                    c = cq.pop_front();
                    got = cpu_rdy ? 0 : (bg_rdy ? 1 : 2);
                    chk("rdy_src", 64'(got), 64'(c.src));
                    chk("rdy_latency", 64'(cyc - rdy_cyc), 64'd1);
                    if (c.src == 0) sh_cpu = c.data[15:0];
                    else if (c.src == 1) sh_bg = c.data[31:0];
                    else sh_spr = c.data;
                    chk("cpu_dout", 64'(cpu_dout), 64'(sh_cpu));
                    chk("bg_dout", 64'(bg_dout), 64'(sh_bg));
                    chk("spr_dout", spr_dout, sh_spr);
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge CLK_96M);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_sdr_req", 64'(sdr_req), 64'd0);
        chk("rst_sdr_addr", 64'(sdr_addr), 64'd0);
        chk("rst_rdys", 64'({cpu_rdy, bg_rdy, spr_rdy}), 64'd0);
        reset_n = 1;

        // Single CPU read.
        cpu_addr = 25'h0012345; cpu_wr_sel = 2'b00; cpu_din = 16'h0;
        push(0, 25'h0012345, 2'b00, 16'h0000, 64'h1122_3344_5566_BEEF, 0);
        check_lat = 1;
        pulse(1, 0, 0);
        run(200, "cpu_read");
        chk("t1_cpu_dout", 64'(cpu_dout), 64'h0000_0000_0000_BEEF);
        chk("t1_bg_dout", 64'(bg_dout), 64'h0);
        chk("t1_spr_dout", spr_dout, 64'h0);

        // CPU write.
        cpu_addr = 25'h0000100; cpu_wr_sel = 2'b10; cpu_din = 16'hA5A5;
        push(0, 25'h0000100, 2'b10, 16'hA5A5, 64'hDEAD_0000_0000_1234, 0);
        pulse(1, 0, 0);
        run(200, "cpu_write");
        chk("t2_cpu_dout", 64'(cpu_dout), 64'h1234);

        // All three in the same cycle: cpu, bg, spr.
        cpu_addr = 25'h0000200; cpu_wr_sel = 2'b00; cpu_din = 16'h0;
        bg_addr = 25'h0100000; spr_addr = 25'h1F00000;
        push(0, 25'h0000200, 2'b00, 16'h0, 64'h0000_0000_0000_C0DE, 0);
        push(1, 25'h0100000, 2'b00, 16'h0, 64'h0000_0000_B6B6_0001, 0);
        push(2, 25'h1F00000, 2'b00, 16'h0, 64'h0123_4567_89AB_CDEF, 0);
        pulse(1, 1, 1);
        run(300, "simultaneous");
        chk("t3_bg_dout", 64'(bg_dout), 64'hB6B6_0001);
        chk("t3_spr_dout", spr_dout, 64'h0123_4567_89AB_CDEF);

        // Starvation cap: four CPU grants, bg, then the CPU again.
        cpu_addr = 25'h0000300; bg_addr = 25'h0100400;
        for (int k = 0; k < 4; k++) begin
            push(0, 25'h0000300 + 25'(k), 2'b00, 16'h0, 64'(16'h3000 + 16'(k)), 0);
            cpu_next.push_back(25'h0000301 + 25'(k));
        end
        push(1, 25'h0100400, 2'b00, 16'h0, 64'h0000_0000_4444_0400, 0);
        push(0, 25'h0000304, 2'b00, 16'h0, 64'h3004, 0);
        pulse(1, 1, 0);
        run(600, "starvation");
        chk("t4_cpu_dout", 64'(cpu_dout), 64'h3004);

        // Reset during WAIT, then a stray sdr_rdy.
        cpu_addr = 25'h00ABCDE;
        push(0, 25'h00ABCDE, 2'b00, 16'h0, 64'h0, 1);
        pulse(1, 0, 0);
        for (int i = 0; i < 20 && !busy; i++) @(negedge CLK_96M);
        repeat (2) @(negedge CLK_96M);
        chk("mid_wait_busy", 64'(busy), 64'd1);
        reset_n = 0;
        #1;
        sh_cpu = 16'h0; sh_bg = 32'h0; sh_spr = 64'h0;
        chk("rst2_busy", 64'(busy), 64'd0);
        chk("rst2_sdr", 64'({sdr_req, sdr_wr_sel, sdr_din}), 64'd0);
        chk("rst2_sdr_addr", 64'(sdr_addr), 64'd0);
        chk("rst2_douts", 64'(cpu_dout) | 64'(bg_dout) | spr_dout, 64'd0);
        @(negedge CLK_96M);
        reset_n = 1;
        stray = 1;
        repeat (6) @(negedge CLK_96M);
        chk("stray_busy", 64'(busy), 64'd0);
        chk("stray_cpu_dout", 64'(cpu_dout), 64'd0);
        cpu_addr = 25'h0000777;
        push(0, 25'h0000777, 2'b00, 16'h0, 64'h0000_0000_0000_5A5A, 0);
        pulse(1, 0, 0);
        run(200, "after_reset");
        chk("t6_cpu_dout", 64'(cpu_dout), 64'h5A5A);

        // Round-robin between continuously requesting bg and spr.
        bg_addr = 25'h0100500; spr_addr = 25'h1F00500;
        push(1, 25'h0100500, 2'b00, 16'h0, 64'h0000_0000_B000_0500, 0);
        push(2, 25'h1F00500, 2'b00, 16'h0, 64'h5000_0000_0000_0500, 0);
        push(1, 25'h0100501, 2'b00, 16'h0, 64'h0000_0000_B000_0501, 0);
        push(2, 25'h1F00501, 2'b00, 16'h0, 64'h5000_0000_0000_0501, 0);
        bg_next.push_back(25'h0100501);
        spr_next.push_back(25'h1F00501);
        pulse(0, 1, 1);
        run(400, "round_robin");
        chk("t5_bg_dout", 64'(bg_dout), 64'hB000_0501);
        chk("t5_spr_dout", spr_dout, 64'h5000_0000_0000_0501);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got time %0t expected completion", $time);
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

endmodule
